// File: rtl/sobel_edge_3x3_gray8.sv
// Streaming 3x3 Sobel edge detector for 8-bit gray video: two ping-pong line buffers and a
// column-shift window feed a gradient / magnitude / threshold pipeline.
module sobel_edge_3x3_gray8 #(
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_valid,
    input  logic [16:0] pixel_addr,
    input  logic        vsync,
    input  logic [7:0]  threshold,
    input  logic        binary_mode,
    output logic [7:0]  edge_out,
    output logic        edge_valid
);

    localparam logic [8:0] W_LIM = 9'(IMG_W);
    localparam logic [7:0] H_LIM = 8'(IMG_H);
    localparam int         AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int         EXTRA = (PIPE_LAT > 3) ? PIPE_LAT - 3 : 0;

    function automatic logic [10:0] colSum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    logic [8:0]        pixX;
    logic [7:0]        pixY;
    logic              accept;
    logic              frameStart;
    logic              selBase;
    logic              selEff;
    logic [AW-1:0]     bufAddr;
    logic [7:0]        lineA [IMG_W];
    logic [7:0]        lineB [IMG_W];
    logic [7:0]        rdA;
    logic [7:0]        rdB;
    logic [7:0]        rowOld;
    logic [7:0]        rowNew;
    logic [7:0]        colTop;
    logic [7:0]        colMid;
    logic [7:0]        t0, t1, t2;
    logic [7:0]        m0, m2;
    logic [7:0]        b0, b1, b2;
    logic signed [10:0] gxComb;
    logic signed [10:0] gyComb;
    logic [10:0]       absGx;
    logic [10:0]       absGy;
    logic [10:0]       magSum;
    logic [7:0]        magSat;
    logic [7:0]        binRes;

    logic              vsyncPrev_q, vsyncPrev_d;
    logic              sel_q, sel_d;
    logic [7:0]        topP1_q, topP1_d, topP2_q, topP2_d;
    logic [7:0]        midP1_q, midP1_d, midP2_q, midP2_d;
    logic [7:0]        botP1_q, botP1_d, botP2_q, botP2_d;
    logic              val1_q, val1_d;
    logic signed [10:0] gx_q, gx_d;
    logic signed [10:0] gy_q, gy_d;
    logic [7:0]        thr1_q, thr1_d;
    logic              mode1_q, mode1_d;
    logic              val2_q, val2_d;
    logic [7:0]        mag2_q, mag2_d;
    logic [7:0]        thr2_q, thr2_d;
    logic              mode2_q, mode2_d;
    logic              val3_q, val3_d;
    logic [7:0]        out3_q, out3_d;

    assign pixX       = pixel_addr[8:0];
    assign pixY       = pixel_addr[16:9];
    assign frameStart = vsync & ~vsyncPrev_q;
    assign accept     = enable & pixel_valid & (pixX < W_LIM) & (pixY < H_LIM);

    // The buffer about to be overwritten is the one still holding row y-2; the select
    // flips at the start of every line, and a frame start forces it back to zero first.
    always_comb begin
        selBase = frameStart ? 1'b0 : sel_q;
        selEff  = (pixX == 9'd0) ? ~selBase : selBase;
        bufAddr = (pixX < W_LIM) ? pixX[AW-1:0] : '0;
        rdA     = lineA[bufAddr];
        rdB     = lineB[bufAddr];
        rowOld  = selEff ? rdB : rdA;
        rowNew  = selEff ? rdA : rdB;
    end

    always_comb begin
        colTop = rowOld;
        colMid = rowNew;
        if (pixY == 8'd0) begin
            colTop = pixel_in;
            colMid = pixel_in;
        end else if (pixY == 8'd1) begin
            colTop = rowNew;
        end
        t2 = colTop;
        m2 = colMid;
        b2 = pixel_in;
        t1 = topP1_q;
        b1 = botP1_q;
        t0 = topP2_q;
        m0 = midP2_q;
        b0 = botP2_q;
        if (pixX == 9'd0) begin
            t1 = t2;
            b1 = b2;
            t0 = t2;
            m0 = m2;
            b0 = b2;
        end else if (pixX == 9'd1) begin
            t0 = topP1_q;
            m0 = midP1_q;
            b0 = botP1_q;
        end
        gxComb = $signed(colSum(t2, m2, b2)) - $signed(colSum(t0, m0, b0));
        gyComb = $signed(colSum(b0, b1, b2)) - $signed(colSum(t0, t1, t2));
    end

    always_comb begin
        absGx  = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
        absGy  = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
        magSum = absGx + absGy;
        magSat = (magSum > 11'd255) ? 8'd255 : magSum[7:0];
        binRes = mode2_q ? ((mag2_q >= thr2_q) ? 8'hFF : 8'h00) : mag2_q;
    end

    // Next state: the window only moves on accepted pixels, while the pipeline advances
    // every clock; a frame start empties the pipeline before the current pixel enters it.
    always_comb begin
        vsyncPrev_d = vsync;
        sel_d       = accept ? selEff : selBase;
        topP1_d     = topP1_q;
        topP2_d     = topP2_q;
        midP1_d     = midP1_q;
        midP2_d     = midP2_q;
        botP1_d     = botP1_q;
        botP2_d     = botP2_q;
        val1_d      = 1'b0;
        gx_d        = gx_q;
        gy_d        = gy_q;
        thr1_d      = thr1_q;
        mode1_d     = mode1_q;
        if (frameStart) begin
            gx_d    = '0;
            gy_d    = '0;
            thr1_d  = '0;
            mode1_d = 1'b0;
        end
        if (accept) begin
            topP1_d = colTop;
            topP2_d = topP1_q;
            midP1_d = colMid;
            midP2_d = midP1_q;
            botP1_d = pixel_in;
            botP2_d = botP1_q;
            val1_d  = 1'b1;
            gx_d    = gxComb;
            gy_d    = gyComb;
            thr1_d  = threshold;
            mode1_d = binary_mode;
        end
        val2_d  = val1_q & ~frameStart;
        mag2_d  = frameStart ? 8'd0 : magSat;
        thr2_d  = frameStart ? 8'd0 : thr1_q;
        mode2_d = mode1_q & ~frameStart;
        val3_d  = val2_q & ~frameStart;
        out3_d  = (val2_q & ~frameStart) ? binRes : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsyncPrev_q <= 1'b0;
            sel_q       <= 1'b0;
            topP1_q     <= '0;
            topP2_q     <= '0;
            midP1_q     <= '0;
            midP2_q     <= '0;
            botP1_q     <= '0;
            botP2_q     <= '0;
            val1_q      <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            thr1_q      <= '0;
            mode1_q     <= 1'b0;
            val2_q      <= 1'b0;
            mag2_q      <= '0;
            thr2_q      <= '0;
            mode2_q     <= 1'b0;
            val3_q      <= 1'b0;
            out3_q      <= '0;
        end else begin
            vsyncPrev_q <= vsyncPrev_d;
            sel_q       <= sel_d;
            topP1_q     <= topP1_d;
            topP2_q     <= topP2_d;
            midP1_q     <= midP1_d;
            midP2_q     <= midP2_d;
            botP1_q     <= botP1_d;
            botP2_q     <= botP2_d;
            val1_q      <= val1_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            thr1_q      <= thr1_d;
            mode1_q     <= mode1_d;
            val2_q      <= val2_d;
            mag2_q      <= mag2_d;
            thr2_q      <= thr2_d;
            mode2_q     <= mode2_d;
            val3_q      <= val3_d;
            out3_q      <= out3_d;
        end
    end

    // Line buffers are deliberately left out of reset; rows are always rewritten before use.
    always_ff @(posedge clk) begin
        if (accept && !rst) begin
            if (selEff) begin
                lineB[bufAddr] <= pixel_in;
            end else begin
                lineA[bufAddr] <= pixel_in;
            end
        end
    end

    if (EXTRA == 0) begin : gDirect
        assign edge_out   = out3_q;
        assign edge_valid = val3_q;
    end else begin : gDelay
        logic [7:0] outSr_q [EXTRA];
        logic       valSr_q [EXTRA];

        // Optional extra output delay for longer latencies, flushed like the core stages.
        always_ff @(posedge clk) begin
            if (rst || frameStart) begin
                for (int i = 0; i < EXTRA; i++) begin
                    outSr_q[i] <= '0;
                    valSr_q[i] <= 1'b0;
                end
            end else begin
                outSr_q[0] <= out3_q;
                valSr_q[0] <= val3_q;
                for (int i = 1; i < EXTRA; i++) begin
                    outSr_q[i] <= outSr_q[i-1];
                    valSr_q[i] <= valSr_q[i-1];
                end
            end
        end

        assign edge_out   = outSr_q[EXTRA-1];
        assign edge_valid = valSr_q[EXTRA-1];
    end

endmodule

// File: tb/tb_sobel_edge_3x3_gray8.sv
// Scoreboard bench for sobel_edge_3x3_gray8: a reference model computes each expected result
// from the bench's own copy of the frame, and a monitor matches them against DUT output pulses.
module tb_sobel_edge_3x3_gray8;

    localparam int W   = 32;
    localparam int H   = 20;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic [16:0] pixel_addr;
    logic        vsync;
    logic [7:0]  threshold;
    logic        binary_mode;
    logic [7:0]  edge_out;
    logic        edge_valid;

    sobel_edge_3x3_gray8 #(
        .IMG_W   (W),
        .IMG_H   (H),
        .PIPE_LAT(LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pixel_in   (pixel_in),
        .pixel_valid(pixel_valid),
        .pixel_addr (pixel_addr),
        .vsync      (vsync),
        .threshold  (threshold),
        .binary_mode(binary_mode),
        .edge_out   (edge_out),
        .edge_valid (edge_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic [7:0] val;
    } expEntry_t;

    expEntry_t  sbq[$];
    expEntry_t  monEntry;
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    bit         monitorOn = 1'b0;
    bit         vsDriven = 1'b0;
    logic [7:0] img [H][W];

    // Border clamping: any row or column before the image edge reuses the edge itself.
    function automatic int px(int r, int c);
        return int'(img[(r < 0) ? 0 : r][(c < 0) ? 0 : c]);
    endfunction

    function automatic logic [7:0] refEdge(int x, int y, logic [7:0] thr, bit mode);
        int gx = 0;
        int gy = 0;
        int mag;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                gx += (j - 1) * ((i == 1) ? 2 : 1) * px(y - 2 + i, x - 2 + j);
                gy += (i - 1) * ((j == 1) ? 2 : 1) * px(y - 2 + i, x - 2 + j);
            end
        end
        mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
        if (mag > 255) mag = 255;
        if (mode) return (mag >= int'(thr)) ? 8'd255 : 8'd0;
        return 8'(mag);
    endfunction

    task automatic flushPending();
        while (sbq.size() > 0 && sbq[$].due > cyc) void'(sbq.pop_back());
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d actual %0d required %0d", name, cyc, actual, required);
        end
    endtask

    // One clock of stimulus; an accepted pixel updates the frame copy and queues its result.
    task automatic applyStimulus(input bit en, input bit vld, input int x, input int y,
                                 input logic [7:0] pix, input logic [7:0] thr, input bit mode,
                                 input bit vs);
        expEntry_t e;
        @(posedge clk);
        #1;
        if (vs && !vsDriven) flushPending();
        vsDriven    = vs;
        enable      = en;
        pixel_valid = vld;
        pixel_addr  = {8'(y), 9'(x)};
        pixel_in    = pix;
        threshold   = thr;
        binary_mode = mode;
        vsync       = vs;
        if (en && vld && x < W && y < H) begin
            img[y][x] = pix;
            e.due = cyc + LAT;
            e.val = refEdge(x, y, thr, mode);
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input bit vs);
        applyStimulus(1'b1, 1'b0, $urandom_range(0, 511), $urandom_range(0, 255),
                      8'($urandom), 8'($urandom), 1'($urandom), vs);
    endtask

    task automatic junkCycle();
        case ($urandom_range(0, 2))
            0: idle(1'b0);
            1: applyStimulus(1'b0, 1'b1, $urandom_range(0, W - 1), $urandom_range(0, H - 1),
                             8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            default: begin
                if ($urandom_range(0, 1) == 0)
                    applyStimulus(1'b1, 1'b1, $urandom_range(W, 511), $urandom_range(0, H - 1),
                                  8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
                else
                    applyStimulus(1'b1, 1'b1, $urandom_range(0, W - 1), $urandom_range(H, 255),
                                  8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            end
        endcase
    endtask

    // kind: 0 flat 100, 1 vertical step, 2 horizontal step, 3 random pixels/threshold/mode.
    task automatic sendFrame(input int kind, input bit mode, input logic [7:0] thrFixed,
                             input int gapPct, input int npix);
        int         sent = 0;
        logic [7:0] pix;
        logic [7:0] thr;
        bit         m;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (sent == npix) return;
                while ($urandom_range(0, 99) < gapPct) junkCycle();
                case (kind)
                    0:       pix = 8'd100;
                    1:       pix = (x < W / 2) ? 8'd0 : 8'd200;
                    2:       pix = (y < H / 2) ? 8'd0 : 8'd50;
                    default: pix = 8'($urandom);
                endcase
                thr = (kind == 3) ? 8'($urandom) : thrFixed;
                m   = (kind == 3) ? 1'($urandom) : mode;
                applyStimulus(1'b1, 1'b1, x, y, pix, thr, m, (x == 0 && y == 0));
                sent++;
            end
        end
    endtask

    task automatic drain(input int n);
        repeat (n) idle(1'b0);
    endtask

    // Monitor: every output pulse must match the oldest outstanding result at its due cycle.
    always @(negedge clk) begin
        if (monitorOn) begin
            if (edge_valid === 1'b1) begin
                pulses++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_valid cycle %0d edge_out %0d required no pulse",
                             cyc, edge_out);
                end else begin
                    monEntry = sbq.pop_front();
                    if (monEntry.due != cyc) begin
                        errors++;
                        $display("[TB] FAIL latency cycle actual %0d required %0d", cyc, monEntry.due);
                    end
                    checks++;
                    if (edge_out !== monEntry.val) begin
                        errors++;
                        $display("[TB] FAIL edge_value cycle %0d actual %0d required %0d",
                                 cyc, edge_out, monEntry.val);
                    end
                end
            end else begin
                checks++;
                if (edge_valid !== 1'b0 || edge_out !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL idle_output cycle %0d actual valid %b out %0d required 0/0",
                             cyc, edge_valid, edge_out);
                end
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    monEntry = sbq.pop_front();
                    checks++;
                    errors++;
                    $display("[TB] FAIL missing_result cycle %0d actual no pulse required %0d due %0d",
                             cyc, monEntry.val, monEntry.due);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog cycle %0d actual still running required finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int n0;
        rst         = 1'b1;
        enable      = 1'b0;
        pixel_valid = 1'b0;
        pixel_addr  = '0;
        pixel_in    = '0;
        vsync       = 1'b0;
        threshold   = '0;
        binary_mode = 1'b0;

        @(posedge clk);
        #1;
        monitorOn = 1'b1;
        @(negedge clk);
        checkOutput("reset_valid", {7'd0, edge_valid}, 8'd0);
        checkOutput("reset_out", edge_out, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] flat frame");
        p0 = pulses;
        sendFrame(0, 1'b0, 8'd0, 0, W * H);
        drain(6);
        checkOutput("flat_pulse_count", 8'(pulses - p0), 8'(W * H));

        $display("[TB] vertical and horizontal steps");
        sendFrame(1, 1'b0, 8'd0, 0, W * H);
        drain(6);
        sendFrame(2, 1'b0, 8'd0, 0, W * H);
        drain(6);
        sendFrame(2, 1'b1, 8'd150, 0, W * H);
        drain(6);

        $display("[TB] random frames with gaps, back to back");
        for (int f = 0; f < 3; f++) sendFrame(3, 1'b0, 8'd0, 20, W * H);
        drain(6);

        $display("[TB] single pixel latency");
        idle(1'b1);
        idle(1'b0);
        drain(4);
        applyStimulus(1'b1, 1'b1, 0, 0, 8'($urandom), 8'd0, 1'b0, 1'b0);
        n0 = cyc;
        for (int i = 1; i <= 5; i++) begin
            idle(1'b0);
            @(negedge clk);
            checkOutput("single_pulse_timing", {7'd0, edge_valid}, {7'd0, (cyc == n0 + LAT)});
        end

        $display("[TB] vsync flush right after pixels");
        sendFrame(3, 1'b0, 8'd0, 0, 10);
        idle(1'b1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            @(negedge clk);
            checkOutput("vsync_flush_valid", {7'd0, edge_valid}, 8'd0);
        end
        idle(1'b0);
        sendFrame(3, 1'b0, 8'd0, 10, W * H);

        $display("[TB] reset pulse mid-line");
        sendFrame(3, 1'b0, 8'd0, 0, W + W / 2);
        @(posedge clk);
        #1;
        flushPending();
        rst         = 1'b1;
        pixel_valid = 1'b0;
        vsync       = 1'b0;
        vsDriven    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", {7'd0, edge_valid}, 8'd0);
        checkOutput("rst_out", edge_out, 8'd0);
        drain(4);
        sendFrame(3, 1'b0, 8'd0, 10, W * H);

        drain(8);
        checkOutput("queue_empty", 8'(sbq.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
